// File: rtl/ntt_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ntt_core                                                   |
// | Description : In-place number theoretic transform over Z_Q, length       |
// |               N = 2^N_LOG2. Coefficients stream in natural order, are    |
// |               transformed with one radix-2 butterfly every two cycles,   |
// |               and stream out in natural order.                           |
// |               Forward: Cooley-Tukey butterflies, len = N/2 down to 1.    |
// |               Inverse: Gentleman-Sande butterflies, len = 1 up to N/2,   |
// |               followed by a per-coefficient scale by NINV.               |
// | Option      : define NTT_INVERSE_EN to build the inverse datapath and    |
// |               the SCALE pass; without it mode is ignored and every       |
// |               transform is forward.                                      |
// | Ports       : clk, rst (async, active-high)                              |
// |               in_valid/in_ready/in_data/mode : coefficient input stream  |
// |               tf_addr/tf_data : synchronous twiddle ROM (1-cycle latency)|
// |               out_valid/out_ready/out_data/out_last : output stream      |
// |               busy : high whenever the FSM is not IDLE                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ntt_core #(
  parameter int N_LOG2 = 8,
  parameter int W      = 23,
  parameter int Q      = 8380417,
  parameter int NINV   = 8347681
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic              mode,
  output logic [N_LOG2-1:0] tf_addr,
  input  logic [W-1:0]      tf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int                N          = 1 << N_LOG2;
  // Layer counter must hold N_LOG2 itself for the inverse twiddle shift.
  localparam int                SW         = $clog2(N_LOG2 + 1);
  localparam logic [W-1:0]      Q_W        = W'(Q);
  localparam logic [2*W-1:0]    Q_2W       = (2*W)'(Q);
  localparam logic [N_LOG2-1:0] LAST_IDX   = N_LOG2'(N - 1);
  localparam logic [N_LOG2-2:0] LAST_BFLY  = '1;
  localparam logic [SW-1:0]     LAST_LAYER = SW'(N_LOG2 - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FETCH = 3'd2,
    CALC  = 3'd3,
    SCALE = 3'd4,
    OUT   = 3'd5
  } state_t;

  state_t            state;
  logic [N_LOG2-1:0] cnt;     // load / scale / output index
  logic [SW-1:0]     layer;   // butterfly layer, 0 = first layer executed
  logic [N_LOG2-2:0] bfly;    // butterfly index within the layer
  logic              inv;     // transform direction latched on first beat
  logic [W-1:0]      xr;
  logic [W-1:0]      yr;
  logic [W-1:0]      mem [N];

  // ------------------------------------------------------------------------
  // Modular helpers
  // ------------------------------------------------------------------------
  function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q_W}) s = s - {1'b0, Q_W};
    return W'(s);
  endfunction

  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
    // When a < b the sum a + (Q - b) is below Q, so it cannot overflow W bits.
    return (a >= b) ? (a - b) : (a + (Q_W - b));
  endfunction

  // ------------------------------------------------------------------------
  // Butterfly addressing. With len = 2^sh, butterfly b of a layer belongs
  // to group g = b >> sh at offset o = b mod len; its pair is
  // (g*2*len + o, g*2*len + o + len). Forward layers shrink len, inverse
  // layers grow it.
  // ------------------------------------------------------------------------
  function automatic logic [SW-1:0] shift_of(input logic [SW-1:0] l, input logic iv);
    return iv ? l : (LAST_LAYER - l);
  endfunction

  function automatic logic [N_LOG2-1:0] x_index(input logic [SW-1:0] l,
                                                input logic [N_LOG2-2:0] b,
                                                input logic iv);
    logic [SW-1:0]     sh;
    logic [N_LOG2-1:0] bb;
    logic [N_LOG2-1:0] grp;
    logic [N_LOG2-1:0] off;
    sh  = shift_of(l, iv);
    bb  = {1'b0, b};
    grp = bb >> sh;
    off = bb & ((N_LOG2'(1) << sh) - N_LOG2'(1));
    // Two shifts so sh+1 never has to fit in SW bits.
    return ((grp << sh) << 1) | off;
  endfunction

  // Global group number k: forward layer l has 2^l - 1 groups before it, so
  // k+1 = 2^l + g. Inverse layer l has N - 2^(N_LOG2-l) groups before it,
  // so N-1-k = 2^(N_LOG2-l) - 1 - g (the l = 0 shift wraps to 0 - 1 = N-1).
  function automatic logic [N_LOG2-1:0] tw_index(input logic [SW-1:0] l,
                                                 input logic [N_LOG2-2:0] b,
                                                 input logic iv);
    logic [N_LOG2-1:0] grp;
    grp = {1'b0, b} >> shift_of(l, iv);
    if (iv) return (N_LOG2'(1) << (SW'(N_LOG2) - l)) - N_LOG2'(1) - grp;
    else    return (N_LOG2'(1) << l) | grp;
  endfunction

  // ------------------------------------------------------------------------
  // Direction latch (only present with the inverse option)
  // ------------------------------------------------------------------------
`ifdef NTT_INVERSE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  inv <= 1'b0;
    else if (state == IDLE && in_valid)       inv <= mode;
  end
`else
  logic unused_mode;
  assign inv         = 1'b0;
  assign unused_mode = mode;
`endif

  // ------------------------------------------------------------------------
  // Combinational datapath
  // ------------------------------------------------------------------------
  logic [N_LOG2-1:0] ix;
  logic [N_LOG2-1:0] iy;
  logic [N_LOG2-1:0] cnt_nx;
  logic [N_LOG2-2:0] bfly_nx;
  logic [SW-1:0]     layer_nx;
  logic              bfly_end;
  logic              layer_end;
  logic [W-1:0]      mul_in;
  logic [W-1:0]      mul_tw;
  logic [W-1:0]      prod;
  logic [W-1:0]      addend;
  logic [W-1:0]      bf_x;
  logic [W-1:0]      bf_y;

  assign ix        = x_index(layer, bfly, inv);
  assign iy        = ix | (N_LOG2'(1) << shift_of(layer, inv));
  assign cnt_nx    = cnt + 1'b1;
  assign bfly_end  = (bfly == LAST_BFLY);
  assign layer_end = (layer == LAST_LAYER);
  assign bfly_nx   = bfly + 1'b1;
  assign layer_nx  = bfly_end ? (layer + 1'b1) : layer;

  // One shared exact multiplier: tf*Y (forward), (X-Y)*(Q-tf) (inverse)
  // or coef*NINV (scale pass).
  always_comb begin
    mul_in = yr;
    mul_tw = tf_data;
`ifdef NTT_INVERSE_EN
    if (state == SCALE) begin
      mul_in = mem[cnt];
      mul_tw = W'(NINV);
    end else if (inv) begin
      mul_in = sub_mod(xr, yr);
      mul_tw = Q_W - tf_data;
    end
`endif
  end

  assign prod   = W'(({{W{1'b0}}, mul_in} * {{W{1'b0}}, mul_tw}) % Q_2W);
  assign addend = inv ? yr : prod;
  assign bf_x   = add_mod(xr, addend);
  assign bf_y   = inv ? prod : sub_mod(xr, addend);

  // ------------------------------------------------------------------------
  // Coefficient memory: port 0 serves load, butterfly X and scale writes,
  // port 1 serves butterfly Y. Contents survive reset.
  // ------------------------------------------------------------------------
  logic              we0;
  logic              we1;
  logic [N_LOG2-1:0] wa0;
  logic [N_LOG2-1:0] wa1;
  logic [W-1:0]      wd0;
  logic [W-1:0]      wd1;

  always_comb begin
    we0 = 1'b0;
    wa0 = cnt;
    wd0 = in_data;
    we1 = 1'b0;
    wa1 = iy;
    wd1 = bf_y;
    case (state)
      IDLE: begin
        we0 = in_valid;
        wa0 = '0;
      end
      LOAD: we0 = in_valid;
      CALC: begin
        we0 = 1'b1;
        wa0 = ix;
        wd0 = bf_x;
        we1 = 1'b1;
      end
`ifdef NTT_INVERSE_EN
      SCALE: begin
        we0 = 1'b1;
        wd0 = prod;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  // ------------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------------
  assign in_ready = (state == IDLE) || (state == LOAD);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      layer     <= '0;
      bfly      <= '0;
      tf_addr   <= '0;
      xr        <= '0;
      yr        <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt   <= N_LOG2'(1);
            state <= LOAD;
          end
        end

        LOAD: begin
          if (in_valid) begin
            cnt <= cnt_nx;
            if (cnt == LAST_IDX) begin
              state   <= FETCH;
              layer   <= '0;
              bfly    <= '0;
              tf_addr <= tw_index('0, '0, inv);
            end
          end
        end

        // Operands are registered here while the ROM looks up tf_addr.
        FETCH: begin
          xr    <= mem[ix];
          yr    <= mem[iy];
          state <= CALC;
        end

        CALC: begin
          bfly  <= bfly_nx;
          layer <= layer_nx;
          if (bfly_end && layer_end) begin
            cnt   <= '0;
            layer <= '0;
            // The final butterfly never touches index 0, so mem[0] is final.
            state     <= OUT;
            out_valid <= 1'b1;
            out_data  <= mem[0];
            out_last  <= 1'b0;
`ifdef NTT_INVERSE_EN
            if (inv) begin
              state     <= SCALE;
              out_valid <= 1'b0;
            end
`endif
          end else begin
            state   <= FETCH;
            tf_addr <= tw_index(layer_nx, bfly_nx, inv);
          end
        end

`ifdef NTT_INVERSE_EN
        SCALE: begin
          cnt <= cnt_nx;
          if (cnt == LAST_IDX) begin
            // mem[0] was rescaled on the first SCALE cycle.
            state     <= OUT;
            out_valid <= 1'b1;
            out_data  <= mem[0];
            out_last  <= 1'b0;
          end
        end
`endif

        OUT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              cnt       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              cnt      <= cnt_nx;
              out_data <= mem[cnt_nx];
              out_last <= (cnt_nx == LAST_IDX);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ntt_core.md
NTT_CORE -- requirements
Module: ntt_core

Interface
REQ-001 The block SHALL have parameter N_LOG2, default 8, meaning log2 of transform length N (N = 2^N_LOG2, 3..10).
REQ-002 The block SHALL have parameter W, default 23, meaning coefficient and twiddle width in bits.
REQ-003 The block SHALL have parameter Q, default 8380417, meaning prime modulus (Q < 2^W).
REQ-004 The block SHALL have parameter NINV, default 8347681, meaning N^-1 mod Q used for inverse scaling.
REQ-005 The block SHALL have clk  input  1  clock.
REQ-006 The block SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-007 The block SHALL have in_valid  input  1  input coefficient valid.
REQ-008 The block SHALL have in_ready  output  1  block accepts a coefficient.
REQ-009 The block SHALL have in_data  input  W  input coefficient, natural order, value < Q.
REQ-010 The block SHALL have mode  input  1  0 = forward NTT, 1 = inverse NTT; sampled on first accepted beat.
REQ-011 The block SHALL have tf_addr  output  N_LOG2  twiddle ROM address.
REQ-012 The block SHALL have tf_data  input  W  twiddle value, valid one cycle after tf_addr (synchronous ROM), plain domain.
REQ-013 The block SHALL have out_valid  output  1  output coefficient valid.
REQ-014 The block SHALL have out_ready  input  1  sink accepts output.
REQ-015 The block SHALL have out_data  output  W  output coefficient, natural order, value in [0,Q).
REQ-016 The block SHALL have out_last  output  1  high with the final (index N-1) coefficient.
REQ-017 The block SHALL have busy  output  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, FETCH, CALC, SCALE, OUT.
REQ-019 in_ready SHALL be high in IDLE and LOAD only; a beat transfers when in_valid & in_ready; the first transfer moves IDLE->LOAD and the N-th moves LOAD->FETCH.
REQ-020 Forward: len = N/2 down to 1, Cooley-Tukey butterfly X'=(X+tf*Y) mod Q, Y'=(X-tf*Y) mod Q, tf_addr = k+1 with k counting groups from 0 across all layers.
REQ-021 Inverse: len = 1 up to N/2, Gentleman-Sande butterfly X'=(X+Y) mod Q, Y'=((X-Y)*(Q-tf)) mod Q, tf_addr = N-1-k.
REQ-022 Each butterfly SHALL take exactly 2 cycles (FETCH drives tf_addr, CALC writes both results); compute phase = N*N_LOG2 cycles.
REQ-023 Modular multiply SHALL be exact (full 2W-bit product reduced mod Q); add/sub results SHALL be in [0,Q).
REQ-024 After the last butterfly, forward goes to OUT; inverse goes to SCALE, multiplying each coefficient by NINV mod Q, one per cycle (N cycles), then OUT.
REQ-025 In OUT, out_valid SHALL be high and out_data/out_last held stable while out_ready is low; index advances only on out_valid & out_ready.
REQ-026 After the beat with out_last accepted, the FSM SHALL return to IDLE and deassert out_valid in the next cycle.
REQ-027 in_valid during FETCH/CALC/SCALE/OUT SHALL be ignored (in_ready low); no coefficient lost or overwritten.

Reset
REQ-028 On rst: state IDLE, all counters 0, out_valid 0, out_last 0, out_data 0, busy 0, tf_addr 0; coefficient memory not cleared.
REQ-029 rst asserted mid-transform SHALL abort it; the next transform SHALL start cleanly from IDLE.

Configuration
REQ-030 With macro NTT_INVERSE_EN defined, inverse mode (REQ-021, REQ-024) SHALL be present; without it, mode SHALL be ignored, SCALE logic omitted, and every transform forward.

Verification
REQ-031 Forward, N=256, input impulse (x[0]=1, rest 0) -> 256 outputs all equal 1, out_last on the 256th.
REQ-032 Forward, all inputs 5 -> output[0..255] match golden model; then inverse of that output -> all 5 (NTT_INVERSE_EN).
REQ-033 Random vector, forward then inverse (NTT_INVERSE_EN) -> bit-exact original input.
REQ-034 out_ready toggled pseudo-randomly 50% during OUT -> out_data stable while stalled, sequence identical to unstalled run.
REQ-035 rst pulsed during compute layer 3, then fresh impulse transform -> all outputs 1, busy low after final beat.
